reg_file_wb: RTL and testbench

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb.sv | 59 +++++
 tb/tb_reg_file_wb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
`timescale 1ns/1ps
`default_nettype none
// reg_file_wb: 2-read/1-write register file with r0 tied to zero and a commit counter.
// Define REG_FILE_WB_BYPASS_EN for combinational write-through forwarding on both read ports.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] READDATA1,
  output logic [DATA_WIDTH-1:0] READDATA2,
  output logic [31:0]           WRITECOUNT
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [31:0]           writecount_q;
  logic [31:0]           writecount_d;
  logic                  kill_q;
  logic                  commit;

  // A reset seen after the last falling edge cancels the write staged at that edge.
  always_ff @(negedge clk or posedge Reset) begin
    if (Reset) kill_q <= 1'b1;
    else       kill_q <= 1'b0;
  end

  assign commit       = RegWrite && (WriteAddress != '0) && !kill_q && !Reset;
  assign writecount_d = commit ? writecount_q + 32'd1 : writecount_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      writecount_q <= '0;
    end else begin
      if (commit) regs_q[WriteAddress] <= WriteData;
      writecount_q <= writecount_d;
    end
  end

  always_comb begin
    READDATA1 = (ReadAddress1 == '0) ? '0 : regs_q[ReadAddress1];
    READDATA2 = (ReadAddress2 == '0) ? '0 : regs_q[ReadAddress2];
`ifdef REG_FILE_WB_BYPASS_EN
    if (commit && (ReadAddress1 == WriteAddress)) READDATA1 = WriteData;
    if (commit && (ReadAddress2 == WriteAddress)) READDATA2 = WriteData;
`endif
  end

  assign WRITECOUNT = writecount_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`timescale 1ns/1ps
`default_nettype none
// tb_reg_file_wb: directed stimulus with a queue-based scoreboard for reg_file_wb.
module tb_reg_file_wb;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_FILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          Reset;
  logic          RegWrite;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddress1;
  logic [AW-1:0] ReadAddress2;
  logic [DW-1:0] READDATA1;
  logic [DW-1:0] READDATA2;
  logic [31:0]   WRITECOUNT;

  reg_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .Reset(Reset), .RegWrite(RegWrite), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
    .READDATA1(READDATA1), .READDATA2(READDATA2), .WRITECOUNT(WRITECOUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0: READDATA1, 1: READDATA2, 2: WRITECOUNT
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] e);
    exp_t t;
    t.name = name; t.sel = sel; t.exp = e;
    sb_q.push_back(t);
  endtask

  task automatic sample();
    #0.1;
    -> sample_ev;
    #0.1;
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    RegWrite = 1'b1; WriteAddress = a; WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin : monitor
    exp_t        t;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        case (t.sel)
          0:       act = READDATA1;
          1:       act = READDATA2;
          default: act = WRITECOUNT;
        endcase
        n_checks++;
        if (act !== t.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", t.name, act, t.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    Reset = 1'b1; RegWrite = 1'b0; WriteAddress = '0; WriteData = '0;
    ReadAddress1 = '0; ReadAddress2 = '0;
    #12;
    ReadAddress1 = 5'd5; ReadAddress2 = 5'd31;
    expect_val("por_rd1", 0, 32'h0);
    expect_val("por_rd2", 1, 32'h0);
    expect_val("por_cnt", 2, 32'h0);
    sample();
    @(negedge clk);
    Reset = 1'b0;

    // basic write/read
    wb_write(5'd5, 32'hDEADBEEF);
    ReadAddress1 = 5'd5;
    expect_val("wr5_rd1", 0, 32'hDEADBEEF);
    expect_val("wr5_cnt", 2, 32'd1);
    sample();

    // writes to r0 are discarded and not counted
    wb_write(5'd0, 32'h12345678);
    ReadAddress1 = 5'd0;
    expect_val("r0_rd1", 0, 32'h0);
    expect_val("r0_cnt", 2, 32'd1);
    sample();

    // same-cycle hazard on read port 2
    wb_write(5'd7, 32'h11);
    @(negedge clk);
    RegWrite = 1'b1; WriteAddress = 5'd7; WriteData = 32'h22; ReadAddress2 = 5'd7;
    expect_val("hazard_pre", 1, BYP ? 32'h22 : 32'h11);
    sample();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    expect_val("hazard_post", 1, 32'h22);
    expect_val("hazard_cnt", 2, 32'd3);
    sample();

    // RegWrite=0 holds array and counter; both ports on the same address
    @(negedge clk);
    RegWrite = 1'b0; WriteAddress = 5'd5; WriteData = 32'h0000FFFF;
    ReadAddress1 = 5'd5; ReadAddress2 = 5'd5;
    @(posedge clk);
    #1;
    expect_val("hold_rd1", 0, 32'hDEADBEEF);
    expect_val("hold_rd2", 1, 32'hDEADBEEF);
    expect_val("hold_cnt", 2, 32'd3);
    sample();

    for (int i = 10; i < 14; i++) wb_write(i[AW-1:0], 32'hA500_0000 | i);
    ReadAddress1 = 5'd10; ReadAddress2 = 5'd13;
    expect_val("fill_rd1_10", 0, 32'hA500_000A);
    expect_val("fill_rd2_13", 1, 32'hA500_000D);
    expect_val("fill_cnt", 2, 32'd7);
    sample();
    ReadAddress1 = 5'd12; ReadAddress2 = 5'd11;
    expect_val("fill_rd1_12", 0, 32'hA500_000C);
    expect_val("fill_rd2_11", 1, 32'hA500_000B);
    sample();

    // asynchronous reset, checked before any clock edge
    @(negedge clk);
    #0.5;
    Reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ReadAddress1 = a[AW-1:0];
      ReadAddress2 = 5'd31 - a[AW-1:0];
      expect_val($sformatf("rst_rd1_%0d", a), 0, 32'h0);
      expect_val($sformatf("rst_rd2_%0d", 31 - a), 1, 32'h0);
      sample();
    end
    expect_val("rst_cnt", 2, 32'h0);
    sample();

    // writes blocked while Reset is held across an edge
    RegWrite = 1'b1; WriteAddress = 5'd9; WriteData = 32'hAA; ReadAddress1 = 5'd9;
    expect_val("rsthold_rd1_pre", 0, 32'h0);
    sample();
    @(posedge clk);
    #1;
    expect_val("rsthold_rd1", 0, 32'h0);
    expect_val("rsthold_cnt", 2, 32'h0);
    sample();
    @(negedge clk);
    Reset = 1'b0; RegWrite = 1'b0;
    wb_write(5'd5, 32'h5555_0005);

    // reset pulse between falling and rising edge cancels the pending write
    @(negedge clk);
    RegWrite = 1'b1; WriteAddress = 5'd9; WriteData = 32'hAA; ReadAddress1 = 5'd9; ReadAddress2 = 5'd5;
    #1;
    Reset = 1'b1;
    expect_val("midrst_rd1_during", 0, 32'h0);
    sample();
    Reset = 1'b0;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    expect_val("midrst_r9", 0, 32'h0);
    expect_val("midrst_r5", 1, 32'h0);
    expect_val("midrst_cnt", 2, 32'h0);
    sample();

    wb_write(5'd9, 32'hAA);
    expect_val("resume_r9", 0, 32'hAA);
    expect_val("resume_cnt", 2, 32'd1);
    sample();

    // counter wrap
    @(negedge clk);
    force dut.writecount_q = 32'hFFFF_FFFF;
    #0.1;
    release dut.writecount_q;
    RegWrite = 1'b1; WriteAddress = 5'd3; WriteData = 32'h33; ReadAddress1 = 5'd3;
    expect_val("wrap_pre_cnt", 2, 32'hFFFF_FFFF);
    sample();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    expect_val("wrap_cnt", 2, 32'h0);
    expect_val("wrap_r3", 0, 32'h33);
    sample();

    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
